// File: rtl/scoreboard_hazard_unit_pkg.sv
// scoreboard_hazard_unit_pkg: shared sizes, latency type and decode-side latency helper
package scoreboard_hazard_unit_pkg;

    localparam int NREGS_DEFAULT = 32;
    localparam int LAT_W_DEFAULT = 3;

    typedef logic [LAT_W_DEFAULT-1:0] lat_t;

    typedef enum logic [1:0] {
        OP_ALU,
        OP_MUL,
        OP_LOAD,
        OP_DIV
    } op_class_e;

    // Forwarding latency decode places in fwd_lat; 0 means the result is only usable at writeback
    function automatic lat_t fwd_lat_of(op_class_e op);
        return (op == OP_ALU) ? lat_t'(1) : (op == OP_MUL) ? lat_t'(3) : lat_t'(0);
    endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_sb_entry.sv
// sb_entry: one architectural register's busy/known/countdown slice
module sb_entry
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int LAT_W  = LAT_W_DEFAULT,
    parameter bit FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             set,
    input  logic             clr,
    input  logic [LAT_W-1:0] lat,
    output logic             busy,
    output logic             fwd_ok
);

    logic             r_busy;
    logic             r_known;
    logic [LAT_W-1:0] r_timer;

    // Issue re-arms (and beats a same-cycle writeback); otherwise writeback clears or the timer counts down
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_busy  <= 1'b0;
            r_known <= 1'b0;
            r_timer <= '0;
        end else if (set) begin
            r_busy  <= 1'b1;
            r_known <= (lat != '0);
            r_timer <= (lat == '0) ? '0 : lat - 1'b1;
        end else if (clr) begin
            r_busy  <= 1'b0;
            r_known <= 1'b0;
            r_timer <= '0;
        end else if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    assign busy   = r_busy;
    assign fwd_ok = FWD_EN && r_known && (r_timer == '0);

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: per-register scoreboard raising RAW/WAW stalls beside decode
module scoreboard_hazard_unit
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int NREGS     = NREGS_DEFAULT,
    parameter int IDX_W     = $clog2(NREGS),
    parameter int LAT_W     = LAT_W_DEFAULT,
    parameter bit FWD_EN    = 1'b1,
    parameter bit BYPASS_WB = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [IDX_W-1:0] id_rs1,
    input  logic [IDX_W-1:0] id_rs2,
    input  logic             id_en_rs1,
    input  logic             id_en_rs2,
    input  logic [IDX_W-1:0] id_rd,
    input  logic             id_en_rd,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             issue_stall,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_rd,
    input  logic             wb_en_rd,
    output logic             data_hazard_ID,
    output logic             issue_fire,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] w_busy;
    logic [NREGS-1:0] w_fwd_ok;
    logic [NREGS-1:0] w_wb_hit;
    logic             w_rdy1;
    logic             w_rdy2;
    logic             w_free;

    // x0 is never tracked, so it is always ready and free
    assign w_busy[0]   = 1'b0;
    assign w_fwd_ok[0] = 1'b0;
    assign w_wb_hit[0] = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : g_entry
        assign w_wb_hit[g] = wb_valid && wb_en_rd && (wb_rd == IDX_W'(g));
        sb_entry #(
            .LAT_W (LAT_W),
            .FWD_EN(FWD_EN)
        ) u_entry (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .set   (issue_fire && id_en_rd && (id_rd == IDX_W'(g))),
            .clr   (w_wb_hit[g]),
            .lat   (id_lat),
            .busy  (w_busy[g]),
            .fwd_ok(w_fwd_ok[g])
        );
    end

    assign w_rdy1 = !w_busy[id_rs1] || w_fwd_ok[id_rs1] || (BYPASS_WB && w_wb_hit[id_rs1]);
    assign w_rdy2 = !w_busy[id_rs2] || w_fwd_ok[id_rs2] || (BYPASS_WB && w_wb_hit[id_rs2]);
    assign w_free = !w_busy[id_rd] || (BYPASS_WB && w_wb_hit[id_rd]);

    assign data_hazard_ID = id_valid && ((id_en_rs1 && !w_rdy1) || (id_en_rs2 && !w_rdy2) || (id_en_rd && !w_free));
    assign issue_fire     = id_valid && !data_hazard_ID && !issue_stall && !flush;
    assign busy_vec       = w_busy;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb_scoreboard_hazard_unit: vector table, corner sequences and randomized model check for both configs
module tb_scoreboard_hazard_unit;
    import scoreboard_hazard_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush, id_valid, id_en_rs1, id_en_rs2, id_en_rd, issue_stall, wb_valid, wb_en_rd;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic [2:0] id_lat;
    logic haz[2];
    logic fire[2];
    logic [31:0] bv[2];

    // Instance 0: forwarding + writeback bypass; instance 1: neither
    scoreboard_hazard_unit #(.FWD_EN(1'b1), .BYPASS_WB(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_en_rs1(id_en_rs1), .id_en_rs2(id_en_rs2),
        .id_rd(id_rd), .id_en_rd(id_en_rd), .id_lat(id_lat), .issue_stall(issue_stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_en_rd(wb_en_rd),
        .data_hazard_ID(haz[0]), .issue_fire(fire[0]), .busy_vec(bv[0]));

    scoreboard_hazard_unit #(.FWD_EN(1'b0), .BYPASS_WB(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_en_rs1(id_en_rs1), .id_en_rs2(id_en_rs2),
        .id_rd(id_rd), .id_en_rd(id_en_rd), .id_lat(id_lat), .issue_stall(issue_stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_en_rd(wb_en_rd),
        .data_hazard_ID(haz[1]), .issue_fire(fire[1]), .busy_vec(bv[1]));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: a register is pending until written back; known producers become usable at cycle ready_at
    bit mb[2][32];
    int mr[2][32];
    logic s_haz[2];
    logic s_fire[2];
    logic [31:0] s_bv[2];

    typedef struct {
        logic v; logic [4:0] rs1; logic e1; logic [4:0] rs2; logic e2;
        logic [4:0] rd; logic erd; logic [2:0] lat; logic st;
        logic wbv; logic [4:0] wbrd; logic fl;
        logic haz; logic fire; logic [31:0] busy;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit m_wbh(int r);
        return wb_valid && wb_en_rd && int'(wb_rd) == r && r != 0;
    endfunction

    function automatic bit m_ready(int k, int r);
        if (r == 0 || !mb[k][r]) return 1'b1;
        return (k == 0) && ((mr[k][r] >= 0 && cyc >= mr[k][r]) || m_wbh(r));
    endfunction

    function automatic bit m_free(int k, int r);
        return r == 0 || !mb[k][r] || (k == 0 && m_wbh(r));
    endfunction

    task automatic step(input bit do_chk);
        bit eh;
        bit ef[2];
        logic [31:0] eb;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            eh = id_valid && ((id_en_rs1 && !m_ready(k, int'(id_rs1))) ||
                              (id_en_rs2 && !m_ready(k, int'(id_rs2))) ||
                              (id_en_rd && !m_free(k, int'(id_rd))));
            ef[k] = id_valid && !eh && !issue_stall && !flush;
            eb = '0;
            for (int r = 0; r < 32; r++) eb[r] = mb[k][r];
            s_haz[k] = haz[k];
            s_fire[k] = fire[k];
            s_bv[k] = bv[k];
            if (do_chk) begin
                chk($sformatf("model%0d.hazard", k), 32'(haz[k]), 32'(eh));
                chk($sformatf("model%0d.fire", k), 32'(fire[k]), 32'(ef[k]));
                chk($sformatf("model%0d.busy_vec", k), bv[k], eb);
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int r = 1; r < 32; r++) begin
                if (reset || flush || m_wbh(r)) begin
                    mb[k][r] = 1'b0;
                    mr[k][r] = -1;
                end
            end
            if (!reset && ef[k] && id_en_rd && id_rd != 0) begin
                mb[k][id_rd] = 1'b1;
                mr[k][id_rd] = (id_lat != 0) ? cyc + int'(id_lat) : -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        reset = 0; flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_en_rs1 = 0; id_en_rs2 = 0;
        id_rd = 0; id_en_rd = 0; id_lat = 0; issue_stall = 0; wb_valid = 0; wb_rd = 0; wb_en_rd = 0;
    endtask

    task automatic apply(input vec_t t);
        idle();
        id_valid = t.v; id_rs1 = t.rs1; id_en_rs1 = t.e1; id_rs2 = t.rs2; id_en_rs2 = t.e2;
        id_rd = t.rd; id_en_rd = t.erd; id_lat = t.lat; issue_stall = t.st;
        wb_valid = t.wbv; wb_rd = t.wbrd; wb_en_rd = t.wbv; flush = t.fl;
    endtask

    initial begin
        //          v  rs1 e1 rs2 e2 rd erd lat st wbv wbrd fl  haz fire busy
        tbl[0]  = '{1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0,  0, 1, 32'h0};
        tbl[1]  = '{1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h8};
        tbl[2]  = '{1, 0, 0, 0, 0, 7, 1, 3, 0, 0, 0, 0,  0, 1, 32'h8};
        tbl[3]  = '{1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h88};
        tbl[4]  = '{1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0,  1, 0, 32'h88};
        tbl[5]  = '{1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h88};
        tbl[6]  = '{1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0,  0, 1, 32'h88};
        tbl[7]  = '{1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h188};
        tbl[8]  = '{1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 8, 0,  0, 1, 32'h188};
        tbl[9]  = '{1, 0, 0, 0, 0, 4, 1, 2, 0, 0, 0, 0,  0, 1, 32'h88};
        tbl[10] = '{1, 0, 0, 0, 0, 4, 1, 0, 0, 1, 4, 0,  0, 1, 32'h98};
        tbl[11] = '{1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h98};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  0, 1, 32'h98};
        tbl[13] = '{1, 0, 0, 0, 0, 9, 1, 1, 1, 0, 0, 0,  0, 0, 32'h98};
        tbl[14] = '{1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0,  0, 1, 32'h98};
        tbl[15] = '{1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 3, 1,  0, 0, 32'h298};
        tbl[16] = '{1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0};
        tbl[17] = '{0, 9, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0,  0, 0, 32'h0};

        for (int k = 0; k < 2; k++) for (int r = 0; r < 32; r++) begin mb[k][r] = 0; mr[k][r] = -1; end
        idle();
        reset = 1; id_valid = 1; id_rs1 = 5; id_en_rs1 = 1;
        @(posedge clk); #1;
        step(1'b1);
        chk("reset.busy_vec", s_bv[0], 32'h0);
        chk("reset.hazard", 32'(s_haz[0]), 32'h0);
        chk("reset.fire", 32'(s_fire[0]), 32'h1);

        cyc = 0;
        for (int i = 0; i < 18; i++) begin
            apply(tbl[i]);
            step(1'b1);
            chk($sformatf("tbl%0d.hazard", i), 32'(s_haz[0]), 32'(tbl[i].haz));
            chk($sformatf("tbl%0d.fire", i), 32'(s_fire[0]), 32'(tbl[i].fire));
            chk($sformatf("tbl%0d.busy_vec", i), s_bv[0], tbl[i].busy);
        end

        // No forwarding, no bypass: an ALU result still waits for the cycle after writeback
        idle(); reset = 1; step(1'b1);
        idle(); id_valid = 1; id_rd = 3; id_en_rd = 1; id_lat = fwd_lat_of(OP_ALU); step(1'b1);
        chk("nofwd.issue", 32'(s_fire[1]), 32'h1);
        idle(); id_valid = 1; id_rs1 = 3; id_en_rs1 = 1; step(1'b1);
        chk("nofwd.fwd_hazard_a", 32'(s_haz[0]), 32'h0);
        chk("nofwd.hazard_c1", 32'(s_haz[1]), 32'h1);
        step(1'b1);
        chk("nofwd.hazard_c2", 32'(s_haz[1]), 32'h1);
        wb_valid = 1; wb_en_rd = 1; wb_rd = 3; step(1'b1);
        chk("nofwd.hazard_wb", 32'(s_haz[1]), 32'h1);
        wb_valid = 0; wb_en_rd = 0; step(1'b1);
        chk("nofwd.after_wb", 32'(s_haz[1]), 32'h0);
        chk("nofwd.after_wb_fire", 32'(s_fire[1]), 32'h1);

        // Randomized traffic on a small register window to force frequent conflicts
        for (int i = 0; i < 400; i++) begin
            idle();
            id_valid = ($urandom_range(0, 4) != 0);
            id_rs1 = 5'($urandom_range(0, 7)); id_en_rs1 = 1'($urandom);
            id_rs2 = 5'($urandom_range(0, 7)); id_en_rs2 = 1'($urandom);
            id_rd = 5'($urandom_range(0, 7)); id_en_rd = 1'($urandom);
            id_lat = 3'($urandom);
            issue_stall = ($urandom_range(0, 4) == 0);
            wb_valid = 1'($urandom); wb_en_rd = ($urandom_range(0, 3) != 0);
            wb_rd = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 31) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
